// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and string packing for the hex reporter.
// HEX_REPORTER_PREFIX_EN inserts "0x" between the colon and the digits.
package uart_pkg;

  localparam logic [7:0] ASCII_COLON   = 8'h3A;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_X       = 8'h78;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;

  localparam int unsigned STR_W = 112;

  localparam logic [7:0] STR_LEN_PLAIN  = 8'd12;
  localparam logic [7:0] STR_LEN_PREFIX = 8'd14;

  localparam logic [1:0] s_IDLE    = 2'd0;
  localparam logic [1:0] s_CONVERT = 2'd1;
  localparam logic [1:0] s_LAUNCH  = 2'd2;
  localparam logic [1:0] s_WAIT    = 2'd3;

`ifdef HEX_REPORTER_PREFIX_EN
  localparam logic [7:0] STR_LEN = STR_LEN_PREFIX;
`else
  localparam logic [7:0] STR_LEN = STR_LEN_PLAIN;
`endif

  // First transmitted byte sits at the top of the active region; unused upper bytes are zero.
  function automatic logic [STR_W-1:0] pack_report(input logic [7:0]  tag,
                                                   input logic [63:0] digits);
`ifdef HEX_REPORTER_PREFIX_EN
    pack_report = {tag, ASCII_COLON, ASCII_ZERO, ASCII_X, digits, ASCII_CR, ASCII_LF};
`else
    pack_report = {16'h0000, tag, ASCII_COLON, digits, ASCII_CR, ASCII_LF};
`endif
  endfunction

endpackage

// File: rtl/uart_nibble_to_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit.
module uart_nibble_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = ASCII_ZERO + {4'h0, i_nibble};
    if (i_nibble > 4'd9) begin
      o_ascii = ASCII_UPPER_A + {4'h0, i_nibble - 4'd10};
    end
  end

endmodule

// File: rtl/uart_hex_reporter.sv
// Formats "<tag>:<8 hex digits>\r\n" and hands it to a string transmitter.
// HEX_REPORTER_PREFIX_EN adds a "0x" prefix before the digits (length 14).
module uart_hex_reporter
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [7:0]         i_tag,
  input  logic [31:0]        i_value,
  output logic               o_txBegin,
  output logic [STR_W-1:0]   o_txData,
  output logic [7:0]         o_txDataLength,
  input  logic               i_txBusy,
  input  logic               i_txDone,
  output logic               o_busy
);

  if (CLOCKS_PER_BIT < 1) begin : g_cpb_check
    $error("CLOCKS_PER_BIT must be positive");
  end

  logic [1:0]       state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_tag_q, hold_tag_d;
  logic [31:0]      hold_val_q, hold_val_d;
  logic [7:0]       work_tag_q, work_tag_d;
  logic [31:0]      work_val_q, work_val_d;
  logic [63:0]      digits_q, digits_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [STR_W-1:0] tx_data_q, tx_data_d;
  logic [7:0]       tx_len_q, tx_len_d;
  logic             tx_begin_q, tx_begin_d;

  logic       accept;
  logic       pop;
  logic [7:0] nib_ascii;

  uart_nibble_to_ascii u_nib (
    .i_nibble (work_val_q[31:28]),
    .o_ascii  (nib_ascii)
  );

  // Handshake: a request transfers on a rising edge where i_valid and o_ready
  // are both high; o_ready means the one-entry holding slot is empty.
  assign accept = i_valid && !hold_full_q;
  assign pop    = (state_q == s_IDLE) && hold_full_q && !i_txBusy;

  always_comb begin
    state_d     = state_q;
    hold_full_d = (hold_full_q && !pop) || accept;
    hold_tag_d  = hold_tag_q;
    hold_val_d  = hold_val_q;
    work_tag_d  = work_tag_q;
    work_val_d  = work_val_q;
    digits_d    = digits_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    tx_len_d    = tx_len_q;
    tx_begin_d  = 1'b0;

    if (accept) begin
      hold_tag_d = i_tag;
      hold_val_d = i_value;
    end

    case (state_q)
      s_IDLE: begin
        if (pop) begin
          work_tag_d = hold_tag_q;
          work_val_d = hold_val_q;
          cnt_d      = 3'd0;
          state_d    = s_CONVERT;
        end
      end
      s_CONVERT: begin
        // Most significant nibble first; the string is frozen on the last digit.
        digits_d   = {digits_q[55:0], nib_ascii};
        work_val_d = {work_val_q[27:0], 4'h0};
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          tx_data_d = pack_report(work_tag_q, digits_d);
          tx_len_d  = STR_LEN;
          state_d   = s_LAUNCH;
        end
      end
      s_LAUNCH: begin
        tx_begin_d = 1'b1;
        state_d    = s_WAIT;
      end
      s_WAIT: begin
        if (i_txDone) begin
          state_d = s_IDLE;
        end
      end
      default: state_d = s_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= s_IDLE;
      hold_full_q <= 1'b0;
      hold_tag_q  <= 8'h00;
      hold_val_q  <= 32'h0;
      work_tag_q  <= 8'h00;
      work_val_q  <= 32'h0;
      digits_q    <= 64'h0;
      cnt_q       <= 3'd0;
      tx_data_q   <= '0;
      tx_len_q    <= 8'h00;
      tx_begin_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_tag_q  <= hold_tag_d;
      hold_val_q  <= hold_val_d;
      work_tag_q  <= work_tag_d;
      work_val_q  <= work_val_d;
      digits_q    <= digits_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      tx_len_q    <= tx_len_d;
      tx_begin_q  <= tx_begin_d;
    end
  end

  assign o_ready        = !hold_full_q;
  assign o_txBegin      = tx_begin_q;
  assign o_txData       = tx_data_q;
  assign o_txDataLength = tx_len_q;
  assign o_busy         = (state_q != s_IDLE);

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Self-checking bench for uart_hex_reporter; honours HEX_REPORTER_PREFIX_EN.
module tb_uart_hex_reporter;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [7:0]   i_tag;
  logic [31:0]  i_value;
  logic         o_txBegin;
  logic [111:0] o_txData;
  logic [7:0]   o_txDataLength;
  logic         i_txBusy;
  logic         i_txDone;
  logic         o_busy;

  logic auto_tx, m_busy, m_done, man_busy, man_done;
  assign i_txBusy = auto_tx ? m_busy : man_busy;
  assign i_txDone = auto_tx ? m_done : man_done;

  uart_hex_reporter #(.CLOCKS_PER_BIT(10)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_tag          (i_tag),
    .i_value        (i_value),
    .o_txBegin      (o_txBegin),
    .o_txData       (o_txData),
    .o_txDataLength (o_txDataLength),
    .i_txBusy       (i_txBusy),
    .i_txDone       (i_txDone),
    .o_busy         (o_busy)
  );

  // clock / reset
  always #5 i_clock = ~i_clock;
  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  // scoreboard state
  logic [119:0] exp_q[$];
  int           lat_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           begin_cnt = 0;
  int           done_cnt = 0;
  logic         prev_begin = 1'b0;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] value;
    logic [63:0] digits;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  function automatic logic [119:0] mk(input logic [7:0] tag, input logic [63:0] digits);
`ifdef HEX_REPORTER_PREFIX_EN
    return {8'd14, tag, 8'h3A, 8'h30, 8'h78, digits, 8'h0D, 8'h0A};
`else
    return {8'd12, 16'h0000, tag, 8'h3A, digits, 8'h0D, 8'h0A};
`endif
  endfunction

  function automatic logic [63:0] hex_digits(input logic [31:0] v);
    logic [63:0] r;
    logic [3:0]  n;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      n = v[31-4*i -: 4];
      r = {r[55:0], (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n})};
    end
    return r;
  endfunction

  // driver: holds valid until the slot is free, then records expectations
  task automatic send(input logic [7:0] tag, input logic [31:0] value,
                      input logic [63:0] digits, input bit chk_lat);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    i_tag   = tag;
    i_value = value;
    while (!o_ready && guard < 400) begin
      @(negedge i_clock);
      guard++;
    end
    if (guard >= 400) fail("send_timeout");
    exp_q.push_back(mk(tag, digits));
    lat_q.push_back(chk_lat ? cyc + 1 : -1);
    @(negedge i_clock);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((o_busy || !o_ready || exp_q.size() != 0 || m_busy) && guard < 600) begin
      @(negedge i_clock);
      guard++;
    end
    if (guard >= 600) fail("wait_idle_timeout");
  endtask

  task automatic wait_begin(input int b0);
    int guard;
    guard = 0;
    while (begin_cnt == b0 && guard < 600) begin
      @(negedge i_clock);
      guard++;
    end
    if (guard >= 600) fail("wait_begin_timeout");
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    done_cnt = begin_cnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_ready, 1'b1);
    check({tag, "_begin"}, o_txBegin, 1'b0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_data"}, o_txData, 112'h0);
    check({tag, "_len"}, o_txDataLength, 8'h00);
  endtask

  // output monitor: pops the scoreboard on every launch pulse
  initial begin
    logic [119:0] e;
    int l;
    forever begin
      @(negedge i_clock);
      if (o_txBegin) begin
        check("begin_order", begin_cnt, done_cnt);
        if (prev_begin) fail("begin_width");
        if (exp_q.size() == 0) begin
          fail("unexpected_begin");
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("tx_length", o_txDataLength, e[119:112]);
          check("tx_string", o_txData, e[111:0]);
          if (l >= 0) check("launch_latency", cyc - l, 10);
        end
        begin_cnt++;
      end
      prev_begin = o_txBegin;
    end
  end

  // transmitter model, active when auto_tx is set
  initial begin
    logic [111:0] held;
    m_busy = 1'b0;
    m_done = 1'b0;
    forever begin
      @(negedge i_clock);
      if (auto_tx && o_txBegin) begin
        held   = o_txData;
        m_busy = 1'b1;
        repeat ($urandom_range(8, 3)) @(negedge i_clock);
        check("data_stable", o_txData, held);
        check("len_stable", o_txDataLength, mk(8'h00, 64'h0) >> 112);
        m_done = 1'b1;
        done_cnt++;
        @(negedge i_clock);
        m_done = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [31:0] rv;
    i_reset = 1'b1; i_valid = 1'b0; i_tag = 8'h00; i_value = 32'h0;
    auto_tx = 1'b1; man_busy = 1'b0; man_done = 1'b0;

    vecs[0] = '{8'h54, 32'h0000BEEF, "0000BEEF"};
    vecs[1] = '{8'h44, 32'h09AF0000, "09AF0000"};
    vecs[2] = '{8'h5A, 32'hFFFFFFFF, "FFFFFFFF"};
    vecs[3] = '{8'h7A, 32'h00000000, "00000000"};
    vecs[4] = '{8'h41, 32'h12345678, "12345678"};

    repeat (3) @(negedge i_clock);
    check_reset_outputs("rst");
    i_reset = 1'b0;
    @(negedge i_clock);

    // table-driven single reports
    foreach (vecs[i]) begin
      send(vecs[i].tag, vecs[i].value, vecs[i].digits, 1'b1);
      wait_idle();
    end
`ifdef HEX_REPORTER_PREFIX_EN
    check("first_byte_A", o_txData[111:104], 8'h41);
`else
    check("upper_bytes_zero", o_txData[111:96], 16'h0000);
    check("first_byte_A", o_txData[95:88], 8'h41);
`endif

    // back-to-back: second waits in the holding slot
    send(8'h31, 32'hDEAD0001, "DEAD0001", 1'b1);
    check("b2b_ready_low", o_ready, 1'b0);
    send(8'h32, 32'hC0FFEE02, "C0FFEE02", 1'b0);
    wait_idle();

    // random burst of consecutive requests
    for (int i = 0; i < 4; i++) begin
      rv = $urandom;
      send(8'h60 + 8'(i), rv, hex_digits(rv), i == 0);
    end
    wait_idle();

    // done outside s_WAIT is ignored; s_WAIT holds until done
    auto_tx = 1'b0;
    @(negedge i_clock);
    b0 = begin_cnt;
    send(8'h52, 32'hA5A55A5A, "A5A55A5A", 1'b1);
    repeat (3) @(negedge i_clock);
    man_done = 1'b1;
    @(negedge i_clock);
    man_done = 1'b0;
    wait_begin(b0);
    repeat (5) @(negedge i_clock);
    check("wait_holds", o_busy, 1'b1);
    man_done = 1'b1;
    done_cnt++;
    @(negedge i_clock);
    man_done = 1'b0;
    check("wait_exit", o_busy, 1'b0);

    // reset in s_WAIT while the transmitter stays busy
    b0 = begin_cnt;
    send(8'h53, 32'h0BADF00D, "0BADF00D", 1'b1);
    wait_begin(b0);
    man_busy = 1'b1;
    repeat (2) @(negedge i_clock);
    pulse_reset();
    check_reset_outputs("rst_wait");
    send(8'h50, 32'hCAFE0123, "CAFE0123", 1'b0);
    b0 = begin_cnt;
    repeat (50) @(negedge i_clock);
    check("no_launch_while_busy", begin_cnt, b0);
    check("pending_held", o_ready, 1'b0);
    check("idle_while_busy", o_busy, 1'b0);
    man_busy = 1'b0;
    wait_begin(b0);
    check("pending_launched", begin_cnt, b0 + 1);
    repeat (2) @(negedge i_clock);
    man_done = 1'b1;
    done_cnt++;
    @(negedge i_clock);
    man_done = 1'b0;

    // reset mid-conversion aborts with no launch
    send(8'h4B, 32'h87654321, "87654321", 1'b1);
    repeat (4) @(negedge i_clock);
    pulse_reset();
    b0 = begin_cnt;
    repeat (20) @(negedge i_clock);
    check("abort_no_begin", begin_cnt, b0);
    check("abort_idle", o_busy, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_hex_reporter.md
UART_HEX_REPORTER -- requirements
Module: uart_hex_reporter

Interface
REQ-001 The module SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameters (name, default, meaning):
  CLOCKS_PER_BIT, 10, passed through for bench timing reference only.
REQ-003 Ports (name, direction, width, meaning):
  i_clock        in   1    sole clock, all logic on rising edge
  i_reset        in   1    synchronous active-high reset
  i_valid        in   1    report request valid
  o_ready        out  1    request holding slot empty
  i_tag          in   8    ASCII tag character
  i_value        in   32   value to report in hex
  o_txBegin      out  1    one-cycle launch pulse to string transmitter
  o_txData       out  112  packed string, first byte at bits [8*len-1 -: 8]
  o_txDataLength out  8    byte count of string
  i_txBusy       in   1    transmitter busy
  i_txDone       in   1    transmitter done pulse
  o_busy         out  1    high in any state other than s_IDLE

Function
REQ-004 A request SHALL be accepted on an edge where i_valid and o_ready are both 1; tag and value are captured into a one-entry holding register.
REQ-005 o_ready SHALL be 1 exactly when the holding register is empty; acceptance SHALL be possible during conversion and transmission.
REQ-006 The states SHALL be s_IDLE, s_CONVERT, s_LAUNCH and s_WAIT.
REQ-007 s_IDLE -> s_CONVERT when the holding register is full and i_txBusy is 0; the entry moves to the working register and the holding register empties on the same edge.
REQ-008 Same-edge holding-register pop and new accept SHALL both take effect; the new request is kept.
REQ-009 s_CONVERT SHALL produce one nibble per cycle, MS nibble first, over 8 cycles, then -> s_LAUNCH.
REQ-010 Nibble mapping: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
REQ-011 String layout, transmitted order: tag, ':' (0x3A), 8 hex digits, CR (0x0D), LF (0x0A); length 12; unused upper bits of o_txData are 0.
REQ-012 s_LAUNCH SHALL assert o_txBegin for exactly one cycle, then -> s_WAIT.
REQ-013 o_txBegin SHALL go high 10 cycles after the accepting edge when the block is idle and i_txBusy is 0.
REQ-014 s_WAIT -> s_IDLE on i_txDone = 1.
REQ-015 o_txData and o_txDataLength SHALL be stable from s_LAUNCH until leaving s_WAIT.
REQ-016 i_txDone seen outside s_WAIT SHALL be ignored.
REQ-017 Back-to-back requests SHALL be emitted in acceptance order, none lost or duplicated.

Reset
REQ-018 On reset: state s_IDLE, holding register empty, o_ready = 1, o_txBegin = 0, o_busy = 0, o_txData = 0, o_txDataLength = 0.
REQ-019 Reset mid-operation SHALL abort immediately with no o_txBegin afterwards.
REQ-020 After reset, a downstream transfer still in progress SHALL complete undisturbed; the next launch waits for i_txBusy = 0 (REQ-007).

Configuration
REQ-021 The feature macro SHALL be HEX_REPORTER_PREFIX_EN.
  Defined: "0x" (0x30, 0x78) is inserted between ':' and the digits; length 14; o_txBegin latency 10 cycles.
  Undefined: layout and length are as in REQ-011.

Structure
REQ-022 Package uart_pkg SHALL hold: ASCII constants (colon, CR, LF, '0', 'x'), the state encodings, the 112-bit string width, and the string lengths 12 and 14.
REQ-023 Nibble-to-ASCII mapping SHALL be a sub-module uart_nibble_to_ascii (4-bit in, 8-bit out, combinational), instantiated once.

Verification
REQ-024 Basic report: tag 0x54, value 0x0000BEEF, i_txBusy = 0 -> o_txBegin 10 cycles after accept; length 12; string "T:0000BEEF\r\n".
REQ-025 Digit range: value 0x09AF0000 -> digits 0x30 0x39 0x41 0x46 0x30 0x30 0x30 0x30.
REQ-026 Back-to-back: two requests on consecutive cycles -> o_ready low after the first until pop; two strings emitted in order; second o_txBegin only after the first i_txDone.
REQ-027 Reset in s_WAIT with i_txBusy held 1 for 50 cycles, request pending -> no o_txBegin until i_txBusy falls; all outputs at reset values one cycle after reset.
REQ-028 HEX_REPORTER_PREFIX_EN defined: value 0x12345678, tag 'A' -> length 14; string "A:0x12345678\r\n"; bits [111:104] = 0x41.
